buzz_arbiter: RTL and testbench

Shares the single piezo `buzz` output between game sound requesters: stage-clear fanfare, enemy hit, player fire, and background music (BGM). A fixed-priority arbiter with one-deep pending latches selects the active source. A tone sub-module generates the square wave for each source for a programmed duration. It sits at the top level on the 100 MHz clock, replacing the direct fire-sound assignment to `buzz`.

---
 rtl/sound_pkg.sv | 46 ++++
 rtl/tone_gen.sv | 33 +++
 rtl/buzz_arbiter.sv | 164 ++++++++++++++++
 tb/tb_buzz_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared sound definitions: arbiter state encoding, active_src codes,
// requester bundle type and default note half-periods in 100 MHz cycles.
// The note constants will also be used by later BGM work.
package sound_pkg;

  localparam int CW_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BGM   = 3'd1,
    ST_FIRE  = 3'd2,
    ST_HIT   = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_FIRE  = 2'b01;
  localparam logic [1:0] SRC_HIT   = 2'b10;
  localparam logic [1:0] SRC_CLEAR = 2'b11;

  // One bit per event requester, highest priority first.
  typedef struct packed {
    logic clear;
    logic hit;
    logic fire;
  } snd_req_t;

  localparam int FIRE_HALF_DEF   = 50000;
  localparam int HIT_HALF_DEF    = 100000;
  localparam int CLEAR_HALF0_DEF = 95556;
  localparam int CLEAR_HALF1_DEF = 75843;
  localparam int CLEAR_HALF2_DEF = 63776;
  localparam int BGM_HALF_A_DEF  = 113636;
  localparam int BGM_HALF_B_DEF  = 151686;

  // BGM counts as "no source".
  function automatic logic [1:0] src_of(input state_e s);
    case (s)
      ST_FIRE:  src_of = SRC_FIRE;
      ST_HIT:   src_of = SRC_HIT;
      ST_CLEAR: src_of = SRC_CLEAR;
      default:  src_of = SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator with a programmable half-period.
//   clk, reset   : clock, async active-high reset
//   restart      : zero the phase counter and force out low on this edge
//   half_period  : half-period in clk cycles (must be nonzero)
//   out          : square wave; first toggle half_period cycles after restart
module tone_gen #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic [CW-1:0] half_period,
  output logic          out
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (cnt == half_period - CW'(1)) begin
      cnt <= '0;
      out <= ~out;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/buzz_arbiter.sv
// Piezo sound arbiter: shares buzz between clear fanfare, hit, fire and BGM.
//   clk, reset   : 100 MHz clock, async active-high reset
//   sound_en     : 0 mutes (buzz low at once, idle and pending cleared next edge)
//   fire_req, hit_req, clear_req : async levels, rising edge requests a tone
//   bgm_en       : BGM plays while no event tone is active
//   buzz         : square wave to the piezo
//   busy         : an event tone (clear/hit/fire) is playing
//   active_src   : 00 none/BGM, 01 fire, 10 hit, 11 clear
// Priority clear > hit > fire > BGM; lower requests wait in one-deep latches.
module buzz_arbiter
  import sound_pkg::*;
#(
  parameter int FIRE_HALF      = FIRE_HALF_DEF,
  parameter int FIRE_CYC       = 5000000,
  parameter int HIT_HALF       = HIT_HALF_DEF,
  parameter int HIT_CYC        = 10000000,
  parameter int CLEAR_HALF0    = CLEAR_HALF0_DEF,
  parameter int CLEAR_HALF1    = CLEAR_HALF1_DEF,
  parameter int CLEAR_HALF2    = CLEAR_HALF2_DEF,
  parameter int CLEAR_NOTE_CYC = 15000000,
  parameter int BGM_HALF_A     = BGM_HALF_A_DEF,
  parameter int BGM_HALF_B     = BGM_HALF_B_DEF,
  parameter int BGM_NOTE_CYC   = 25000000,
  parameter int CW             = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound_en,
  input  logic       fire_req,
  input  logic       hit_req,
  input  logic       clear_req,
  input  logic       bgm_en,
  output logic       buzz,
  output logic       busy,
  output logic [1:0] active_src
);

  // 2-flop synchronizer plus one history flop for edge detect.
  logic [2:0] s1, s2, s3;
  snd_req_t   rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {clear_req, hit_req, fire_req};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = snd_req_t'(s2 & ~s3 & {3{sound_en}});

  state_e        state, nxt_state, top;
  logic [CW-1:0] dur, nxt_dur;
  logic [1:0]    note, nxt_note;
  logic          pend_h, pend_f, nxt_ph, nxt_pf;
  logic          restart, done, free;
  snd_req_t      cand;

  always_comb begin
    done = 1'b0;
    case (state)
      ST_FIRE:  done = (dur == CW'(FIRE_CYC - 1));
      ST_HIT:   done = (dur == CW'(HIT_CYC - 1));
      ST_CLEAR: done = (dur == CW'(CLEAR_NOTE_CYC - 1)) && (note == 2'd2);
      default:  done = 1'b0;
    endcase
    // "free": nothing will be playing after this edge unless we pick something.
    free = done || (state == ST_IDLE) || (state == ST_BGM);
    // Pending latches only compete once the current event has ended.
    cand.clear = rise.clear;
    cand.hit   = rise.hit  | (free & pend_h);
    cand.fire  = rise.fire | (free & pend_f);
    top = cand.clear ? ST_CLEAR : cand.hit ? ST_HIT : cand.fire ? ST_FIRE : ST_IDLE;

    // Default: continue the current tone.
    nxt_state = state;
    nxt_dur   = dur + CW'(1);
    nxt_note  = note;
    nxt_ph    = pend_h | rise.hit;
    nxt_pf    = pend_f | rise.fire;
    restart   = 1'b0;
    if (state == ST_CLEAR && dur == CW'(CLEAR_NOTE_CYC - 1)) begin
      nxt_dur  = '0;
      nxt_note = note + 2'd1;
      restart  = 1'b1;
    end
    if (state == ST_BGM && dur == CW'(BGM_NOTE_CYC - 1)) begin
      nxt_dur  = '0;
      nxt_note = {1'b0, ~note[0]};
      restart  = 1'b1;
    end

    if (!sound_en) begin
      nxt_state = ST_IDLE;
      nxt_dur   = '0;
      nxt_note  = '0;
      nxt_ph    = 1'b0;
      nxt_pf    = 1'b0;
      restart   = 1'b1;
    end else if (top != ST_IDLE && (free || top >= state)) begin
      // Preempt (higher) or restart (equal); the preempted event is dropped.
      nxt_state = top;
      nxt_dur   = '0;
      nxt_note  = '0;
      restart   = 1'b1;
      nxt_ph    = (pend_h | rise.hit)  & (top != ST_HIT);
      nxt_pf    = (pend_f | rise.fire) & (top != ST_FIRE);
    end else if (free && top == ST_IDLE && !(state == ST_BGM && bgm_en)) begin
      nxt_state = bgm_en ? ST_BGM : ST_IDLE;
      nxt_dur   = '0;
      nxt_note  = '0;
      restart   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      dur        <= '0;
      note       <= '0;
      pend_h     <= 1'b0;
      pend_f     <= 1'b0;
      busy       <= 1'b0;
      active_src <= SRC_NONE;
    end else begin
      state      <= nxt_state;
      dur        <= nxt_dur;
      note       <= nxt_note;
      pend_h     <= nxt_ph;
      pend_f     <= nxt_pf;
      busy       <= (nxt_state == ST_FIRE) || (nxt_state == ST_HIT) || (nxt_state == ST_CLEAR);
      active_src <= src_of(nxt_state);
    end
  end

  logic [CW-1:0] half;
  logic          tone;

  always_comb begin
    half = CW'(FIRE_HALF);
    case (state)
      ST_HIT:   half = CW'(HIT_HALF);
      ST_BGM:   half = note[0] ? CW'(BGM_HALF_B) : CW'(BGM_HALF_A);
      ST_CLEAR: half = (note == 2'd0) ? CW'(CLEAR_HALF0) :
                       (note == 2'd1) ? CW'(CLEAR_HALF1) : CW'(CLEAR_HALF2);
      default:  half = CW'(FIRE_HALF);
    endcase
  end

  tone_gen #(.CW(CW)) u_tone (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .half_period (half),
    .out         (tone)
  );

  assign buzz = sound_en & tone & (state != ST_IDLE);

endmodule

// File: tb/tb_buzz_arbiter.sv
// Bench for buzz_arbiter with scaled timing: directed scenarios followed by
// random request traffic, all checked against a time-since-entry model.
module tb_buzz_arbiter;

  localparam int FH = 4, FC = 40, HH = 6, HC = 60;
  localparam int CH0 = 3, CH1 = 5, CH2 = 7, CN = 30;
  localparam int BHA = 2, BHB = 3, BN = 20;

  logic clk = 1'b0, reset = 1'b1;
  logic sound_en = 1'b1, fire_req = 1'b0, hit_req = 1'b0, clear_req = 1'b0, bgm_en = 1'b0;
  logic buzz, busy;
  logic [1:0] active_src;

  int n_pass = 0, n_tot = 0;

  buzz_arbiter #(
    .FIRE_HALF(FH), .FIRE_CYC(FC), .HIT_HALF(HH), .HIT_CYC(HC),
    .CLEAR_HALF0(CH0), .CLEAR_HALF1(CH1), .CLEAR_HALF2(CH2), .CLEAR_NOTE_CYC(CN),
    .BGM_HALF_A(BHA), .BGM_HALF_B(BHB), .BGM_NOTE_CYC(BN), .CW(32)
  ) dut (
    .clk(clk), .reset(reset), .sound_en(sound_en), .fire_req(fire_req),
    .hit_req(hit_req), .clear_req(clear_req), .bgm_en(bgm_en),
    .buzz(buzz), .busy(busy), .active_src(active_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: mode 0 idle, 1 bgm, 2 fire, 3 hit, 4 clear; t = cycles since entry.
  int m_mode = 0, m_t = 0;
  logic [2:0] m_pend = '0;          // bit0 fire, bit1 hit, bit2 clear
  logic [2:0] h1 = '0, h2 = '0, h3 = '0;

  function automatic int ev_len(input int md);
    case (md)
      2: return FC;
      3: return HC;
      4: return 3 * CN;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_buzz();
    int loc, hp;
    case (m_mode)
      1: begin loc = m_t % BN; hp = ((m_t / BN) % 2) ? BHB : BHA; return 1'((loc / hp) % 2); end
      2: return 1'((m_t / FH) % 2);
      3: return 1'((m_t / HH) % 2);
      4: begin
        loc = m_t % CN;
        hp = (m_t / CN == 0) ? CH0 : (m_t / CN == 1) ? CH1 : CH2;
        return 1'((loc / hp) % 2);
      end
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [2:0] rise, cand;
    int best;
    bit fr;
    if (reset) begin
      m_mode = 0; m_t = 0; m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
    end else begin
      // A request seen at edge n-2 but not n-3 is detected at edge n.
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = {clear_req, hit_req, fire_req};
      if (!sound_en) begin
        m_mode = 0; m_t = 0; m_pend = '0;
      end else begin
        fr = (m_mode < 2) || (m_t + 1 == ev_len(m_mode));
        cand = rise | (fr ? m_pend : 3'b000);
        best = cand[2] ? 4 : cand[1] ? 3 : cand[0] ? 2 : 0;
        if (best != 0 && (fr || best >= m_mode)) begin
          m_pend = (m_pend | rise) & ~(3'b001 << (best - 2));
          m_mode = best; m_t = 0;
        end else if (best != 0) begin
          m_pend = m_pend | rise; m_t++;
        end else if (fr) begin
          if (m_mode == 1 && bgm_en) m_t++;
          else if (bgm_en) begin m_mode = 1; m_t = 0; end
          else begin m_mode = 0; m_t = 0; end
        end else m_t++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_buzz", 32'(buzz), 32'(sound_en & m_buzz()));
      chk("model_busy", 32'(busy), 32'(m_mode >= 2));
      chk("model_src", 32'(active_src), (m_mode >= 2) ? 32'(m_mode - 1) : 32'd0);
    end
  end

  initial begin
    int tog;
    logic pb;

    // Reset state
    adv(3);
    chk("rst_buzz", 32'(buzz), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_src", 32'(active_src), 0);
    reset = 1'b0;
    adv(3);
    chk("idle_src", 32'(active_src), 0);

    // Single fire: detect at k+2, 10 toggles across 40 cycles, busy drops at 40
    fire_req = 1'b1;
    adv(1); chk("fire_k", 32'(active_src), 0);
    adv(1); chk("fire_k1", 32'(active_src), 0);
    fire_req = 1'b0;
    adv(1); chk("fire_k2_src", 32'(active_src), 1);
    chk("fire_k2_buzz", 32'(buzz), 0);
    tog = 0; pb = buzz;
    for (int i = 1; i <= 40; i++) begin
      adv(1);
      if (buzz !== pb) tog++;
      pb = buzz;
      if (i == 4) chk("fire_first_tog", 32'(buzz), 1);
      if (i == 39) chk("fire_busy39", 32'(busy), 1);
      if (i == 40) chk("fire_busy40", 32'(busy), 0);
    end
    chk("fire_toggles", 32'(tog), 10);
    adv(3);

    // Reset mid-tone acts asynchronously
    fire_req = 1'b1; adv(2); fire_req = 1'b0; adv(1);
    adv(10);
    chk("mid_busy_pre", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_buzz", 32'(buzz), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_src", 32'(active_src), 0);
    adv(2); reset = 1'b0;
    adv(3);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_buzz", 32'(buzz), 0);

    // HIT playing, fire goes pending and runs afterwards
    hit_req = 1'b1; adv(2); hit_req = 1'b0; adv(1);
    chk("hit_src", 32'(active_src), 2);
    adv(10);
    fire_req = 1'b1; adv(2); fire_req = 1'b0; adv(1);
    chk("hit_not_preempted", 32'(active_src), 2);
    adv(46); chk("hit_t59", 32'(active_src), 2);
    adv(1);  chk("pend_fire_start", 32'(active_src), 1);
    adv(39); chk("pend_fire_t39", 32'(active_src), 1);
    adv(1);  chk("pend_fire_end", 32'(active_src), 0);
    adv(3);

    // FIRE preempted by HIT, fire dropped
    fire_req = 1'b1; adv(2); fire_req = 1'b0; adv(1);
    adv(5);
    hit_req = 1'b1; adv(2); hit_req = 1'b0; adv(1);
    chk("preempt_hit", 32'(active_src), 2);
    adv(59); chk("preempt_hit_t59", 32'(active_src), 2);
    adv(1);  chk("fire_dropped", 32'(active_src), 0);
    adv(3);

    // Simultaneous requests: CLEAR, HIT, FIRE, idle
    clear_req = 1'b1; hit_req = 1'b1; fire_req = 1'b1;
    adv(2);
    clear_req = 1'b0; hit_req = 1'b0; fire_req = 1'b0;
    adv(1);  chk("sim_clear", 32'(active_src), 3);
    adv(3);  chk("sim_clear_tog0", 32'(buzz), 1);
    adv(86); chk("sim_clear_t89", 32'(active_src), 3);
    adv(1);  chk("sim_hit", 32'(active_src), 2);
    adv(59); chk("sim_hit_t59", 32'(active_src), 2);
    adv(1);  chk("sim_fire", 32'(active_src), 1);
    adv(39); chk("sim_fire_t39", 32'(active_src), 1);
    adv(1);  chk("sim_idle", 32'(active_src), 0);
    adv(3);

    // BGM, interrupted by fire, resumes at note A
    bgm_en = 1'b1;
    adv(1); chk("bgm_busy", 32'(busy), 0);
    adv(2); chk("bgm_tog", 32'(buzz), 1);
    adv(42);
    fire_req = 1'b1; adv(2); fire_req = 1'b0; adv(1);
    chk("bgm_fire", 32'(active_src), 1);
    adv(40);
    chk("bgm_resume_src", 32'(active_src), 0);
    chk("bgm_resume_buzz", 32'(buzz), 0);
    adv(2); chk("bgm_resume_tog", 32'(buzz), 1);
    bgm_en = 1'b0;
    adv(1); chk("bgm_off_buzz", 32'(buzz), 0);
    adv(3);

    // Mute during HIT with fire pending
    hit_req = 1'b1; adv(2); hit_req = 1'b0; adv(1);
    adv(5);
    fire_req = 1'b1; adv(2); fire_req = 1'b0; adv(1);
    adv(2);
    chk("mute_pre_buzz", 32'(buzz), 1);
    sound_en = 1'b0;
    #1 chk("mute_comb_buzz", 32'(buzz), 0);
    adv(1);
    chk("mute_idle_src", 32'(active_src), 0);
    chk("mute_idle_busy", 32'(busy), 0);
    fire_req = 1'b1; adv(2); fire_req = 1'b0; adv(3);
    sound_en = 1'b1;
    adv(100);
    chk("unmute_src", 32'(active_src), 0);
    chk("unmute_buzz", 32'(buzz), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) fire_req = ~fire_req;
      if ($urandom_range(59) == 0) hit_req = ~hit_req;
      if ($urandom_range(99) == 0) clear_req = ~clear_req;
      if ($urandom_range(149) == 0) bgm_en = ~bgm_en;
      if ($urandom_range(299) == 0) sound_en = ~sound_en;
      else if (!sound_en && $urandom_range(9) == 0) sound_en = 1'b1;
      adv(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
